// File: rtl/fx2_slave_fifo_if.sv
// FX2 slave-FIFO strobes and flags plus the host valid/ready channels of fx2_slave_fifo.
// FDATA is bidirectional and stays a plain port on the module.
interface fx2_slave_fifo_if;
  logic        SLRD;
  logic        SLWR;
  logic        SLOE;
  logic [1:0]  FIFOADR;
  logic        PKTEND;
  logic        FLAGA;
  logic        FLAGD;
  logic        h_out_valid;
  logic [15:0] h_out_data;
  logic        h_out_ready;
  logic        h_in_valid;
  logic [15:0] h_in_data;
  logic        h_in_ready;

  modport master (
    output SLRD, SLWR, SLOE, FIFOADR, PKTEND,
    input  FLAGA, FLAGD,
    output h_out_valid, h_out_data,
    input  h_out_ready,
    input  h_in_valid, h_in_data,
    output h_in_ready
  );

  modport slave (
    input  SLRD, SLWR, SLOE, FIFOADR, PKTEND,
    output FLAGA, FLAGD,
    input  h_out_valid, h_out_data,
    output h_out_ready,
    output h_in_valid, h_in_data,
    input  h_in_ready
  );
endinterface

// File: rtl/fx2_slave_fifo.sv
// FX2LP slave-FIFO responder: EP2 (host->FPGA) and EP6 (FPGA->host) FWFT word FIFOs, one-cycle update, full/empty backpressure.
// Define FX2_PKTEND_EN to hold EP6 words from the host until committed by PKTEND or a full PKT_WORDS packet.
module fx2_slave_fifo #(
  parameter int DEPTH     = 512,
  parameter int AW        = 9,
  parameter int PKT_WORDS = 256
) (
  input  logic            CLKOUT,
  input  logic            rst_n,
  fx2_slave_fifo_if.slave bus,
  inout  wire  [15:0]     FDATA,
  output logic [AW:0]     ep2_count,
  output logic [AW:0]     ep6_count,
  output logic            err_ovf,
  output logic            err_unf,
  output logic            err_proto
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [15:0]   ep2_mem_q [DEPTH];
  logic [15:0]   ep6_mem_q [DEPTH];

  logic [AW-1:0] ep2_wr_q, ep2_wr_d, ep2_rd_q, ep2_rd_d;
  logic [AW-1:0] ep6_wr_q, ep6_wr_d, ep6_rd_q, ep6_rd_d;
  logic [AW:0]   ep2_cnt_q, ep2_cnt_d, ep6_cnt_q, ep6_cnt_d;
  logic [AW:0]   ep6_vis_q, ep6_vis_d;
  logic [15:0]   last_pop_q, last_pop_d;
  logic          err_ovf_q, err_ovf_d, err_unf_q, err_unf_d, err_proto_q, err_proto_d;

  logic          rd, wr, adr_ep2, adr_ep6, adr_bad;
  logic          ep2_empty, ep2_full, ep6_full;
  logic          push2, pop2, push6, pop6;
  logic          fdata_oe;
  logic [15:0]   fdata_out;

  always_comb begin
    rd        = ~bus.SLRD;
    wr        = ~bus.SLWR;
    adr_ep2   = (bus.FIFOADR == 2'b00);
    adr_ep6   = (bus.FIFOADR == 2'b10);
    adr_bad   = bus.FIFOADR[0];
    ep2_empty = (ep2_cnt_q == '0);
    ep2_full  = (ep2_cnt_q == FULL_CNT);
    ep6_full  = (ep6_cnt_q == FULL_CNT);
    // A strobe only acts when it is the sole strobe and addresses its own endpoint.
    pop2      = rd & ~wr & adr_ep2 & ~ep2_empty;
    push6     = wr & ~rd & adr_ep6 & ~ep6_full;
    push2     = bus.h_out_valid & rst_n & ~ep2_full;
    pop6      = bus.h_in_ready & (ep6_vis_q != '0);
    fdata_oe  = ~bus.SLOE & adr_ep2;
    fdata_out = ep2_empty ? last_pop_q : ep2_mem_q[ep2_rd_q];
  end

  always_comb begin
    ep2_wr_d    = ep2_wr_q + AW'(push2);
    ep2_rd_d    = ep2_rd_q + AW'(pop2);
    ep2_cnt_d   = ep2_cnt_q + (AW+1)'(push2) - (AW+1)'(pop2);
    ep6_wr_d    = ep6_wr_q + AW'(push6);
    ep6_rd_d    = ep6_rd_q + AW'(pop6);
    ep6_cnt_d   = ep6_cnt_q + (AW+1)'(push6) - (AW+1)'(pop6);
    last_pop_d  = pop2 ? ep2_mem_q[ep2_rd_q] : last_pop_q;
    err_unf_d   = err_unf_q | (rd & ~wr & adr_ep2 & ep2_empty);
    err_ovf_d   = err_ovf_q | (wr & ~rd & adr_ep6 & ep6_full);
    err_proto_d = err_proto_q | (rd & wr) | ((rd | wr) & adr_bad);
  end

`ifdef FX2_PKTEND_EN
  localparam logic [AW:0] PKT_CNT = (AW+1)'(PKT_WORDS);
  logic [AW:0] uncommitted;

  // The word pushed alongside PKTEND belongs to the packet being closed.
  always_comb begin
    uncommitted = ep6_cnt_q - ep6_vis_q + (AW+1)'(push6);
    ep6_vis_d   = ep6_vis_q - (AW+1)'(pop6);
    if ((uncommitted >= PKT_CNT) || (~bus.PKTEND && (uncommitted != '0))) begin
      ep6_vis_d = ep6_vis_d + uncommitted;
    end
  end
`else
  localparam int unused_pkt_words = PKT_WORDS;
  logic unused_pktend;
  assign unused_pktend = bus.PKTEND;

  always_comb begin
    ep6_vis_d = ep6_cnt_d;
  end
`endif

  always_ff @(posedge CLKOUT) begin
    if (!rst_n) begin
      ep2_wr_q    <= '0;
      ep2_rd_q    <= '0;
      ep2_cnt_q   <= '0;
      ep6_wr_q    <= '0;
      ep6_rd_q    <= '0;
      ep6_cnt_q   <= '0;
      ep6_vis_q   <= '0;
      last_pop_q  <= '0;
      err_ovf_q   <= 1'b0;
      err_unf_q   <= 1'b0;
      err_proto_q <= 1'b0;
    end else begin
      ep2_wr_q    <= ep2_wr_d;
      ep2_rd_q    <= ep2_rd_d;
      ep2_cnt_q   <= ep2_cnt_d;
      ep6_wr_q    <= ep6_wr_d;
      ep6_rd_q    <= ep6_rd_d;
      ep6_cnt_q   <= ep6_cnt_d;
      ep6_vis_q   <= ep6_vis_d;
      last_pop_q  <= last_pop_d;
      err_ovf_q   <= err_ovf_d;
      err_unf_q   <= err_unf_d;
      err_proto_q <= err_proto_d;
    end
  end

  // Storage is never cleared; pointers and counts alone define validity.
  always_ff @(posedge CLKOUT) begin
    if (push2) ep2_mem_q[ep2_wr_q] <= bus.h_out_data;
    if (push6 && rst_n) ep6_mem_q[ep6_wr_q] <= FDATA;
  end

  assign FDATA           = fdata_oe ? fdata_out : 16'hzzzz;
  assign bus.FLAGA       = ~ep2_empty;
  assign bus.FLAGD       = ~ep6_full;
  assign bus.h_out_ready = rst_n & ~ep2_full;
  assign bus.h_in_valid  = (ep6_vis_q != '0);
  assign bus.h_in_data   = ep6_mem_q[ep6_rd_q];
  assign ep2_count       = ep2_cnt_q;
  assign ep6_count       = ep6_cnt_q;
  assign err_ovf         = err_ovf_q;
  assign err_unf         = err_unf_q;
  assign err_proto       = err_proto_q;

endmodule

// File: tb/tb_fx2_slave_fifo.sv
// Self-checking bench for fx2_slave_fifo: directed scenarios plus randomized traffic against a queue model.
module tb_fx2_slave_fifo;
  localparam int DEPTH = 512;
  localparam int AW    = 9;
`ifdef FX2_PKTEND_EN
  localparam logic PKTEND_IDLE = 1'b0;
`else
  localparam logic PKTEND_IDLE = 1'b1;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fx2_slave_fifo_if bus();
  wire  [15:0] fdata;
  logic [15:0] tb_dat;
  logic        tb_oe;
  assign fdata = tb_oe ? tb_dat : 16'hzzzz;

  logic [AW:0] ep2_count, ep6_count;
  logic        err_ovf, err_unf, err_proto;

  fx2_slave_fifo #(.DEPTH(DEPTH), .AW(AW), .PKT_WORDS(256)) dut (
    .CLKOUT(clk), .rst_n(rst_n), .bus(bus), .FDATA(fdata),
    .ep2_count(ep2_count), .ep6_count(ep6_count),
    .err_ovf(err_ovf), .err_unf(err_unf), .err_proto(err_proto)
  );

  logic [15:0] m2[$];
  logic [15:0] m6[$];
  logic [15:0] m_last;
  logic        m_ovf, m_unf, m_proto;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tb_oe = 1'b0;
    bus.SLRD = 1'b1; bus.SLWR = 1'b1; bus.SLOE = 1'b1; bus.FIFOADR = 2'b00;
    bus.PKTEND = PKTEND_IDLE;
    bus.h_out_valid = 1'b0; bus.h_out_data = '0; bus.h_in_ready = 1'b0;
    tb_dat = '0;
  endtask

  task automatic clear_model();
    m2.delete(); m6.delete();
    m_last = '0; m_ovf = 1'b0; m_unf = 1'b0; m_proto = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    clear_model();
  endtask

  // act: 0 none, 1 SLRD EP2, 2 SLWR EP6, 3 SLRD+SLWR, 4 SLRD with FIFOADR=01
  task automatic drive_cycle(input logic hp, input logic [15:0] hd, input logic hr,
                             input int act, input logic [15:0] wd, input logic pkt_n);
    int sz2, sz6;
    sz2 = m2.size(); sz6 = m6.size();
    tb_oe = 1'b0;
    bus.SLRD = !(act == 1 || act == 3 || act == 4);
    bus.SLWR = !(act == 2 || act == 3);
    bus.SLOE = (act == 2);
    bus.FIFOADR = (act == 2) ? 2'b10 : (act == 4) ? 2'b01 : 2'b00;
    bus.PKTEND = pkt_n;
    tb_dat = wd; tb_oe = (act == 2);
    bus.h_out_valid = hp; bus.h_out_data = hd; bus.h_in_ready = hr;
    tick();
    if (act == 1) begin
      if (sz2 > 0) m_last = m2.pop_front();
      else m_unf = 1'b1;
    end
    if (hp && sz2 < DEPTH) m2.push_back(hd);
    if (hr && sz6 > 0) void'(m6.pop_front());
    if (act == 2) begin
      if (sz6 < DEPTH) m6.push_back(wd);
      else m_ovf = 1'b1;
    end
    if (act == 3 || act == 4) m_proto = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    tick();
    n_checks++; if (bus.h_out_ready !== 1'b0) begin n_fail++; $display("FAIL reset_h_out_ready: got %b want 0", bus.h_out_ready); end
    tick();
    rst_n = 1'b1;
    clear_model();
    #1;
    n_checks++; if (bus.FLAGA !== 1'b0) begin n_fail++; $display("FAIL reset_flaga: got %b want 0", bus.FLAGA); end
    n_checks++; if (bus.FLAGD !== 1'b1) begin n_fail++; $display("FAIL reset_flagd: got %b want 1", bus.FLAGD); end
    n_checks++; if (bus.h_in_valid !== 1'b0) begin n_fail++; $display("FAIL reset_h_in_valid: got %b want 0", bus.h_in_valid); end
    n_checks++; if (bus.h_out_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", bus.h_out_ready); end
    n_checks++; if (ep2_count !== '0 || ep6_count !== '0) begin n_fail++; $display("FAIL reset_counts: got %0d/%0d want 0/0", ep2_count, ep6_count); end
    n_checks++; if ({err_ovf, err_unf, err_proto} !== 3'b000) begin n_fail++; $display("FAIL reset_errs: got %b want 000", {err_ovf, err_unf, err_proto}); end
  endtask

  task automatic test_ep2_read();
    do_reset();
    for (int i = 1; i <= 18; i++) begin
      drive_cycle(1'b1, 16'(i), 1'b0, 0, '0, PKTEND_IDLE);
      if ($urandom_range(0, 1) == 1) drive_cycle(1'b0, '0, 1'b0, 0, '0, PKTEND_IDLE);
    end
    n_checks++; if (ep2_count !== 10'd18) begin n_fail++; $display("FAIL t1_count: got %0d want 18", ep2_count); end
    n_checks++; if (bus.FLAGA !== 1'b1) begin n_fail++; $display("FAIL t1_flaga_full: got %b want 1", bus.FLAGA); end
    for (int k = 0; k < 18; k++) begin
      n_checks++; if (fdata !== 16'(k + 1)) begin n_fail++; $display("FAIL t1_fdata: got %h want %h", fdata, 16'(k + 1)); end
      drive_cycle(1'b0, '0, 1'b0, 1, '0, PKTEND_IDLE);
      if ($urandom_range(0, 2) == 0) drive_cycle(1'b0, '0, 1'b0, 0, '0, PKTEND_IDLE);
    end
    n_checks++; if (bus.FLAGA !== 1'b0) begin n_fail++; $display("FAIL t1_flaga_empty: got %b want 0", bus.FLAGA); end
    n_checks++; if (fdata !== 16'h0012) begin n_fail++; $display("FAIL t1_last_pop: got %h want 0012", fdata); end
    n_checks++; if ({err_ovf, err_unf, err_proto} !== 3'b000) begin n_fail++; $display("FAIL t1_errs: got %b want 000", {err_ovf, err_unf, err_proto}); end
  endtask

  task automatic test_ep6_write();
    do_reset();
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, '0, 1'b0, 2, 16'(16'hA0 + i), PKTEND_IDLE);
    idle();
    n_checks++; if (ep6_count !== 10'd4) begin n_fail++; $display("FAIL t2_count: got %0d want 4", ep6_count); end
    n_checks++; if (bus.h_in_valid !== 1'b1) begin n_fail++; $display("FAIL t2_valid: got %b want 1", bus.h_in_valid); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (bus.h_in_data !== 16'(16'hA0 + i)) begin n_fail++; $display("FAIL t2_data: got %h want %h", bus.h_in_data, 16'(16'hA0 + i)); end
      drive_cycle(1'b0, '0, 1'b1, 0, '0, PKTEND_IDLE);
    end
    n_checks++; if (bus.h_in_valid !== 1'b0 || ep6_count !== '0) begin n_fail++; $display("FAIL t2_drained: got valid=%b count=%0d want 0/0", bus.h_in_valid, ep6_count); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < DEPTH; i++) drive_cycle(1'b0, '0, 1'b0, 2, 16'($urandom), PKTEND_IDLE);
    n_checks++; if (ep6_count !== 10'd512) begin n_fail++; $display("FAIL t3_count_full: got %0d want 512", ep6_count); end
    n_checks++; if (bus.FLAGD !== 1'b0) begin n_fail++; $display("FAIL t3_flagd: got %b want 0", bus.FLAGD); end
    n_checks++; if (err_ovf !== 1'b0) begin n_fail++; $display("FAIL t3_ovf_early: got %b want 0", err_ovf); end
    drive_cycle(1'b0, '0, 1'b0, 2, 16'hDEAD, PKTEND_IDLE);
    n_checks++; if (err_ovf !== 1'b1) begin n_fail++; $display("FAIL t3_ovf: got %b want 1", err_ovf); end
    n_checks++; if (ep6_count !== 10'd512) begin n_fail++; $display("FAIL t3_count_hold: got %0d want 512", ep6_count); end
    while (m6.size() > 0) begin
      n_checks++; if (bus.h_in_data !== m6[0]) begin n_fail++; $display("FAIL t3_drain_data: got %h want %h", bus.h_in_data, m6[0]); end
      drive_cycle(1'b0, '0, 1'b1, 0, '0, PKTEND_IDLE);
    end
    n_checks++; if (ep6_count !== '0 || bus.FLAGD !== 1'b1) begin n_fail++; $display("FAIL t3_drained: got count=%0d flagd=%b want 0/1", ep6_count, bus.FLAGD); end
  endtask

  task automatic test_errors();
    do_reset();
    drive_cycle(1'b0, '0, 1'b0, 1, '0, PKTEND_IDLE);
    n_checks++; if ({err_ovf, err_unf, err_proto} !== 3'b010) begin n_fail++; $display("FAIL t4_unf: got %b want 010", {err_ovf, err_unf, err_proto}); end
    do_reset();
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 16'(16'h300 + i), 1'b0, 0, '0, PKTEND_IDLE);
    for (int i = 0; i < 2; i++) drive_cycle(1'b0, '0, 1'b0, 2, 16'(16'h600 + i), PKTEND_IDLE);
    drive_cycle(1'b0, '0, 1'b0, 3, '0, PKTEND_IDLE);
    n_checks++; if ({err_ovf, err_unf, err_proto} !== 3'b001) begin n_fail++; $display("FAIL t4_proto: got %b want 001", {err_ovf, err_unf, err_proto}); end
    n_checks++; if (ep2_count !== 10'd3 || ep6_count !== 10'd2) begin n_fail++; $display("FAIL t4_counts: got %0d/%0d want 3/2", ep2_count, ep6_count); end
    n_checks++; if (fdata !== 16'h0300) begin n_fail++; $display("FAIL t4_head: got %h want 0300", fdata); end
    do_reset();
    drive_cycle(1'b0, '0, 1'b0, 4, '0, PKTEND_IDLE);
    n_checks++; if ({err_ovf, err_unf, err_proto} !== 3'b001) begin n_fail++; $display("FAIL t4_badaddr: got %b want 001", {err_ovf, err_unf, err_proto}); end
  endtask

  task automatic test_random();
    int act, last_act;
    do_reset();
    last_act = 0;
    for (int c = 0; c < 400; c++) begin
      n_checks++; if (ep2_count !== (AW+1)'(m2.size()) || ep6_count !== (AW+1)'(m6.size())) begin n_fail++; $display("FAIL rnd_counts: got %0d/%0d want %0d/%0d", ep2_count, ep6_count, m2.size(), m6.size()); end
      n_checks++; if (bus.FLAGA !== (m2.size() != 0) || bus.FLAGD !== (m6.size() != DEPTH)) begin n_fail++; $display("FAIL rnd_flags: got %b%b", bus.FLAGA, bus.FLAGD); end
      n_checks++; if (bus.h_in_valid !== (m6.size() != 0)) begin n_fail++; $display("FAIL rnd_h_in_valid: got %b want %b", bus.h_in_valid, m6.size() != 0); end
      if (m6.size() != 0) begin
        n_checks++; if (bus.h_in_data !== m6[0]) begin n_fail++; $display("FAIL rnd_h_in_data: got %h want %h", bus.h_in_data, m6[0]); end
      end
      if (last_act == 0 || last_act == 1 || last_act == 3) begin
        n_checks++; if (fdata !== ((m2.size() != 0) ? m2[0] : m_last)) begin n_fail++; $display("FAIL rnd_fdata: got %h want %h", fdata, (m2.size() != 0) ? m2[0] : m_last); end
      end
      n_checks++; if ({err_ovf, err_unf, err_proto} !== {m_ovf, m_unf, m_proto}) begin n_fail++; $display("FAIL rnd_errs: got %b want %b", {err_ovf, err_unf, err_proto}, {m_ovf, m_unf, m_proto}); end
      act = $urandom_range(0, 19);
      act = (act < 6) ? 0 : (act < 12) ? 1 : (act < 18) ? 2 : (act == 18) ? 3 : 4;
      drive_cycle(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)), act, 16'($urandom), PKTEND_IDLE);
      last_act = act;
    end
  endtask

`ifdef FX2_PKTEND_EN
  task automatic test_pktend();
    do_reset();
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, '0, 1'b0, 2, 16'(16'hC0 + i), 1'b1);
    n_checks++; if (bus.h_in_valid !== 1'b0 || ep6_count !== 10'd3) begin n_fail++; $display("FAIL t5_uncommitted: got valid=%b count=%0d want 0/3", bus.h_in_valid, ep6_count); end
    drive_cycle(1'b0, '0, 1'b0, 0, '0, 1'b0);
    n_checks++; if (bus.h_in_valid !== 1'b1) begin n_fail++; $display("FAIL t5_commit: got %b want 1", bus.h_in_valid); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (bus.h_in_data !== 16'(16'hC0 + i)) begin n_fail++; $display("FAIL t5_data: got %h want %h", bus.h_in_data, 16'(16'hC0 + i)); end
      drive_cycle(1'b0, '0, 1'b1, 0, '0, 1'b1);
    end
    for (int i = 0; i < 255; i++) drive_cycle(1'b0, '0, 1'b0, 2, 16'(i), 1'b1);
    n_checks++; if (bus.h_in_valid !== 1'b0) begin n_fail++; $display("FAIL t5_partial_pkt: got %b want 0", bus.h_in_valid); end
    drive_cycle(1'b0, '0, 1'b0, 2, 16'hFF, 1'b1);
    n_checks++; if (bus.h_in_valid !== 1'b1 || ep6_count !== 10'd256) begin n_fail++; $display("FAIL t5_auto_commit: got valid=%b count=%0d want 1/256", bus.h_in_valid, ep6_count); end
  endtask
`endif

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 10; i++) drive_cycle(1'b1, 16'(16'h700 + i), 1'b0, 0, '0, PKTEND_IDLE);
    drive_cycle(1'b0, '0, 1'b0, 3, '0, PKTEND_IDLE);
    drive_cycle(1'b0, '0, 1'b0, 1, '0, PKTEND_IDLE);
    rst_n = 1'b0;
    bus.h_out_valid = 1'b1; bus.h_out_data = 16'hBEEF;
    tick(); tick();
    rst_n = 1'b1;
    idle();
    clear_model();
    #1;
    n_checks++; if (ep2_count !== '0 || bus.FLAGA !== 1'b0) begin n_fail++; $display("FAIL t6_ep2: got count=%0d flaga=%b want 0/0", ep2_count, bus.FLAGA); end
    n_checks++; if ({err_ovf, err_unf, err_proto} !== 3'b000) begin n_fail++; $display("FAIL t6_errs: got %b want 000", {err_ovf, err_unf, err_proto}); end
    drive_cycle(1'b1, 16'h5A5A, 1'b0, 0, '0, PKTEND_IDLE);
    n_checks++; if (fdata !== 16'h5A5A || ep2_count !== 10'd1) begin n_fail++; $display("FAIL t6_resume: got %h/%0d want 5a5a/1", fdata, ep2_count); end
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    clear_model();
    test_reset();
    test_ep2_read();
    test_ep6_write();
    test_overflow();
    test_errors();
    test_random();
`ifdef FX2_PKTEND_EN
    test_pktend();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
